// File: rtl/score_disp_pkg.sv
// Shared types, constants and the BCD-digit to seven-segment lookup for the score display.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         SCORE_MAX = 127;

  // Number of BCD bits needed to hold SCORE_MAX in decimal.
  localparam int BCD_W = 4 * ((SCORE_MAX > 99) ? 3 : ((SCORE_MAX > 9) ? 2 : 1));

  // Active-high segments, bit0=a .. bit6=g, bit7 (dp) always 0.
  // Non-decimal nibbles render blank.
  function automatic logic [7:0] seg_lut(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_encode.sv
// One BCD nibble to seven-segment pattern, with a forced-blank input.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd_i (digit), blank_i (force 00), seg_o (segments, dp=0).
module bcd_seg_encode
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_lut(bcd_i);

endmodule

// File: rtl/score_display_driver.sv
// Binary score -> three BCD digits (sequential double-dabble) -> seven-segment, with blink.
// Latency: 8 cycles from the capture edge to new segments; blink gating is combinational on a register.
// Backpressure: none; score changes during a conversion are picked up on the next idle cycle.
// Ports: clk, nRst (async active-low), dispScore, isGameComplete (blink enable),
//        ss_ones/ss_tens/ss_hundreds (segments), busy (conversion in progress).
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int SCORE_W   = 7,
  parameter int BLINK_DIV = 50
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [SCORE_W-1:0] dispScore,
  input  logic               isGameComplete,
  output logic [7:0]         ss_ones,
  output logic [7:0]         ss_tens,
  output logic [7:0]         ss_hundreds,
  output logic               busy
);

  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] shreg_q, shreg_d;
  logic [SCORE_W-1:0] cap_q, cap_d;
  logic [SCORE_W-1:0] shown_q, shown_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               committed_q, committed_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    shown_d     = shown_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    committed_d = committed_q;
    case (state_q)
      IDLE: begin
        if (dispScore != shown_q) begin
          shreg_d = dispScore;
          cap_d   = dispScore;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        dig_d       = bcd_q;
        shown_d     = cap_q;
        committed_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink timer: off/on phases of BLINK_DIV cycles, starting with "on".
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (isGameComplete) begin
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cap_q       <= '0;
      shown_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      dig_q       <= '0;
      committed_q <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      shown_q     <= shown_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      committed_q <= committed_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Tens/hundreds read 00 out of reset until a conversion has been committed;
  // with leading-zero blanking the zero digits also stay dark afterwards.
  logic blank_hund, blank_tens;
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_hund = !committed_q || (dig_q[11:8] == 4'd0);
  assign blank_tens = !committed_q || ((dig_q[11:8] == 4'd0) && (dig_q[7:4] == 4'd0));
`else
  assign blank_hund = !committed_q;
  assign blank_tens = !committed_q;
`endif

  logic [7:0] seg_ones, seg_tens, seg_hund;

  bcd_seg_encode u_enc_ones (
    .bcd_i   (dig_q[3:0]),
    .blank_i (1'b0),
    .seg_o   (seg_ones)
  );

  bcd_seg_encode u_enc_tens (
    .bcd_i   (dig_q[7:4]),
    .blank_i (blank_tens),
    .seg_o   (seg_tens)
  );

  bcd_seg_encode u_enc_hund (
    .bcd_i   (dig_q[11:8]),
    .blank_i (blank_hund),
    .seg_o   (seg_hund)
  );

  assign ss_ones     = blink_off_q ? SEG_BLANK : seg_ones;
  assign ss_tens     = blink_off_q ? SEG_BLANK : seg_tens;
  assign ss_hundreds = blink_off_q ? SEG_BLANK : seg_hund;

endmodule

// File: tb/tb_score_display_driver.sv
module tb_score_display_driver;

  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       nRst;
  logic [6:0] dispScore;
  logic       isGameComplete;
  logic [7:0] ss_ones, ss_tens, ss_hundreds;
  logic       busy;

  initial forever #5 clk = ~clk;

  score_display_driver #(.SCORE_W(7), .BLINK_DIV(BLINK)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .dispScore      (dispScore),
    .isGameComplete (isGameComplete),
    .ss_ones        (ss_ones),
    .ss_tens        (ss_tens),
    .ss_hundreds    (ss_hundreds),
    .busy           (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] segtab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Reference model: displayed value, cycles left in a conversion,
  // and length of the current run of game-complete edges.
  int m_shown, m_cap, m_left, m_run;
  bit m_comm;

  task automatic model_reset();
    m_shown = 0; m_cap = 0; m_left = 0; m_run = 0; m_comm = 0;
  endtask

  task automatic model_edge();
    if (!nRst) begin
      model_reset();
      return;
    end
    if (isGameComplete) m_run++;
    else m_run = 0;
    if (m_left == 0) begin
      if (int'(dispScore) != m_shown) begin
        m_cap  = int'(dispScore);
        m_left = 8;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_shown = m_cap;
        m_comm  = 1;
      end
    end
  endtask

  // pos: 0 = ones, 1 = tens, 2 = hundreds
  function automatic logic [7:0] exp_ss(input int pos);
    int h, t, o;
    h = m_shown / 100;
    t = (m_shown / 10) % 10;
    o = m_shown % 10;
    if (((m_run / BLINK) % 2) == 1) return 8'h00;
    if (pos == 0) return segtab[o];
    if (!m_comm) return 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 1) return (h == 0 && t == 0) ? 8'h00 : segtab[t];
    return (h == 0) ? 8'h00 : segtab[h];
`else
    if (pos == 1) return segtab[t];
    return segtab[h];
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic check_model();
    chk("model_ones", ss_ones, exp_ss(0));
    chk("model_tens", ss_tens, exp_ss(1));
    chk("model_hund", ss_hundreds, exp_ss(2));
    chk("model_busy", {7'd0, busy}, {7'd0, (m_left != 0)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // 1. reset
    nRst = 1'b0; dispScore = 7'd0; isGameComplete = 1'b0;
    model_reset();
    #12;
    chk("rst_ones", ss_ones, 8'h3F);
    chk("rst_tens", ss_tens, 8'h00);
    chk("rst_hund", ss_hundreds, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    nRst = 1'b1;
    steps(3);
    chk("idle0_busy", {7'd0, busy}, 8'h00);
    chk("idle0_ones", ss_ones, 8'h3F);

    // 2. 0 -> 42, busy after edges k..k+7, result after k+8
    dispScore = 7'd42;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("conv42_busy", {7'd0, busy}, 8'h01);
    end
    step();
    chk("conv42_busy_done", {7'd0, busy}, 8'h00);
    chk("conv42_ones", ss_ones, 8'h5B);
    chk("conv42_tens", ss_tens, 8'h66);
`ifdef LEADING_ZERO_BLANK_EN
    chk("conv42_hund", ss_hundreds, 8'h00);
`else
    chk("conv42_hund", ss_hundreds, 8'h3F);
`endif

    // 3. maximum score, then single digit
    dispScore = 7'd127;
    steps(9);
    chk("max_hund", ss_hundreds, 8'h06);
    chk("max_tens", ss_tens, 8'h5B);
    chk("max_ones", ss_ones, 8'h07);
    dispScore = 7'd5;
    steps(9);
    chk("five_ones", ss_ones, 8'h6D);
`ifdef LEADING_ZERO_BLANK_EN
    chk("five_tens", ss_tens, 8'h00);
    chk("five_hund", ss_hundreds, 8'h00);
`else
    chk("five_tens", ss_tens, 8'h3F);
    chk("five_hund", ss_hundreds, 8'h3F);
`endif

    // 4. input change mid-conversion
    dispScore = 7'd42;
    steps(4);                 // edges k..k+3
    dispScore = 7'd99;
    steps(5);                 // edge k+8
    chk("stale_ones", ss_ones, 8'h5B);
    chk("stale_tens", ss_tens, 8'h66);
    chk("stale_busy", {7'd0, busy}, 8'h00);
    step();                   // edge k+9
    chk("recapture_busy", {7'd0, busy}, 8'h01);
    steps(8);                 // edge k+17
    chk("fix99_ones", ss_ones, 8'h6F);
    chk("fix99_tens", ss_tens, 8'h6F);
    chk("fix99_busy", {7'd0, busy}, 8'h00);

    // 5. blink with score 42
    dispScore = 7'd42;
    steps(10);
    isGameComplete = 1'b1;
    chk("blink_c0", ss_ones, 8'h5B);
    for (int i = 1; i < BLINK; i++) begin
      step();
      chk("blink_on1", ss_ones, 8'h5B);
    end
    step();
    chk("blink_off_ones", ss_ones, 8'h00);
    chk("blink_off_tens", ss_tens, 8'h00);
    chk("blink_off_hund", ss_hundreds, 8'h00);
    step();
    chk("blink_off2", ss_tens, 8'h00);
    isGameComplete = 1'b0;
    step();
    chk("blink_restore", ss_ones, 8'h5B);
    for (int i = 0; i < 2 * BLINK; i++) begin
      step();
      chk("blink_stay_on", ss_tens, 8'h66);
    end

    // 6. reset during SHIFT
    dispScore = 7'd100;
    steps(3);
    #3;
    nRst = 1'b0;
    #1;
    model_reset();
    chk("midrst_ones", ss_ones, 8'h3F);
    chk("midrst_tens", ss_tens, 8'h00);
    chk("midrst_hund", ss_hundreds, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    check_model();
    #2;
    nRst = 1'b1;
    step();
    chk("postrst_busy", {7'd0, busy}, 8'h01);
    steps(8);
    chk("c100_hund", ss_hundreds, 8'h06);
    chk("c100_tens", ss_tens, 8'h3F);
    chk("c100_ones", ss_ones, 8'h3F);

    // 7. randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) dispScore = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 11) == 0) isGameComplete = ~isGameComplete;
      nRst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
